// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MDU_FAST_MUL_EN to compute multiplies with a combinational multiplier.
module mdu_iter #(
  parameter int W = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         s_clk_i,
  input  logic         s_reset_i,
  input  logic         s_flush_i,
  input  logic         s_start_i,
  input  logic [2:0]   s_funct_i,
  input  logic [W-1:0] s_op1_i,
  input  logic [W-1:0] s_op2_i,
  output logic         s_busy_o,
  output logic         s_done_o,
  output logic [W-1:0] s_result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_funct;
  logic          r_neg, r_spec, r_done;
  logic [W-1:0]  r_b, r_spec_val, r_result;
  logic [2*W:0]  r_acc;

  logic         w_accept, w_sg1, w_sg2, w_s1, w_s2, w_neg;
  logic         w_div0, w_ovf, w_mz, w_spec, w_fast, w_qb;
  logic [W-1:0] w_abs1, w_abs2, w_spec_val;
  logic [W-1:0] w_dv, w_dv_s, w_res;
  logic [W:0]   w_sum, w_rsh;
  logic [W+1:0] w_diff;
  logic [2*W:0] w_mstep, w_dstep;
  logic [2*W-1:0] w_prod, w_prod_s;

  assign w_accept = (r_state == IDLE) & s_start_i & ~s_flush_i;

  assign w_sg1 = s_funct_i inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign w_sg2 = s_funct_i inside {3'd1, 3'd4, 3'd6};
  assign w_s1 = w_sg1 & s_op1_i[W-1];
  assign w_s2 = w_sg2 & s_op2_i[W-1];
  assign w_abs1 = w_s1 ? -s_op1_i : s_op1_i;
  assign w_abs2 = w_s2 ? -s_op2_i : s_op2_i;
  // remainder takes the dividend's sign, everything else the xor
  assign w_neg = (s_funct_i == 3'd6) ? w_s1 : (w_s1 ^ w_s2);

  assign w_div0 = s_funct_i[2] & (s_op2_i == '0);
  assign w_ovf = w_sg2 & s_funct_i[2]
               & (s_op1_i == {1'b1, {(W-1){1'b0}}})
               & (&s_op2_i);
  assign w_mz = ~s_funct_i[2]
              & ((s_op1_i == '0) | (s_op2_i == '0));
  assign w_spec = w_div0 | w_ovf | w_mz;

  always_comb begin
    w_spec_val = '0;
    if (w_div0)
      w_spec_val = s_funct_i[1] ? s_op1_i : '1;
    else if (w_ovf)
      w_spec_val = s_funct_i[1] ? '0 : s_op1_i;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*W+1:0] w_fp;
  assign w_fast = ~s_funct_i[2];
  assign w_fp = $signed({1'b0, r_acc[W-1:0]})
              * $signed({1'b0, r_b});
  assign w_prod = w_fp[2*W-1:0];
`else
  assign w_fast = 1'b0;
  assign w_prod = r_acc[2*W-1:0];
`endif

  assign w_sum = r_acc[2*W:W]
               + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mstep = {1'b0, w_sum, r_acc[W-1:1]};

  assign w_rsh = r_acc[2*W-1:W-1];
  assign w_diff = {1'b0, w_rsh} - {2'b0, r_b};
  assign w_qb = ~w_diff[W+1];
  assign w_dstep = {w_qb ? w_diff[W:0] : w_rsh,
                    r_acc[W-2:0], w_qb};

  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_dv = r_funct[1] ? r_acc[2*W-1:W] : r_acc[W-1:0];
  assign w_dv_s = r_neg ? -w_dv : w_dv;

  always_comb begin
    w_res = w_dv_s;
    if (r_spec)
      w_res = r_spec_val;
    else if (!r_funct[2])
      w_res = (r_funct[1:0] == 2'd0) ? w_prod_s[W-1:0]
                                     : w_prod_s[2*W-1:W];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (w_spec | w_fast) ? FIN : CALC;
      CALC: if (r_cnt == CW'(1)) w_next = FIN;
      FIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (s_flush_i) w_next = IDLE;
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_cnt <= '0;
      r_funct <= '0;
      r_neg <= 1'b0;
      r_spec <= 1'b0;
      r_b <= '0;
      r_spec_val <= '0;
      r_acc <= '0;
      r_result <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (s_flush_i) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: if (s_start_i) begin
            r_cnt <= CW'(W);
            r_funct <= s_funct_i;
            r_neg <= w_neg;
            r_spec <= w_spec;
            r_spec_val <= w_spec_val;
            r_b <= w_abs2;
            r_acc <= {{(W+1){1'b0}}, w_abs1};
          end
          CALC: begin
            r_acc <= r_funct[2] ? w_dstep : w_mstep;
            r_cnt <= r_cnt - CW'(1);
          end
          FIN: begin
            r_result <= w_res;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign s_busy_o = (r_state != IDLE);
  assign s_done_o = r_done;
  assign s_result_o = r_result;

endmodule
